// File: rtl/multiplier_sequencer_if.sv
// Bundles the operand/product channels and the multiplier-core handshake of multiplier_sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding environment (producer, consumer, core).
interface multiplier_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_multiplicand;
  logic [WIDTH-1:0]     in_multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 mul_start;
  logic                 mul_ready;
  logic [WIDTH-1:0]     mul_multiplicand;
  logic [WIDTH-1:0]     mul_multiplier;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 busy;

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, out_ready, mul_ready, mul_product,
    output in_ready, out_valid, out_product, mul_start, mul_multiplicand, mul_multiplier, busy
  );

  modport master (
    output in_valid, in_multiplicand, in_multiplier, out_ready, mul_ready, mul_product,
    input  in_ready, out_valid, out_product, mul_start, mul_multiplicand, mul_multiplier, busy
  );
endinterface

// File: rtl/multiplier_sequencer.sv
// Command/response adapter around the shift-and-add multiplier core: one operation in flight.
// Optional MULTIPLIER_SEQUENCER_ZERO_BYPASS_EN: zero operands skip the core and return 0 directly.
module multiplier_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  multiplier_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_capture;
  logic [2*WIDTH-1:0]   w_capture_val;
  logic                 w_zero_op;
  logic [WIDTH-1:0]     r_multiplicand;
  logic [WIDTH-1:0]     r_multiplier;
  logic [2*WIDTH-1:0]   r_product;

`ifdef MULTIPLIER_SEQUENCER_ZERO_BYPASS_EN
  assign w_zero_op = (bus.in_multiplicand == '0) || (bus.in_multiplier == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  // Next-state and capture decode
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_capture_val = bus.mul_product;
    case (r_state)
      S_IDLE: begin
        // A core ready left over from an earlier operation is deliberately ignored here.
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (w_zero_op) begin
            w_capture     = 1'b1;
            w_capture_val = '0;
            w_state_nxt   = S_OUTPUT;
          end else begin
            w_state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (bus.mul_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait for the core to drop ready so the next launch starts from a clean handshake.
        if (!bus.mul_ready) begin
          w_state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, operand and product registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_product      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_multiplicand <= bus.in_multiplicand;
        r_multiplier   <= bus.in_multiplier;
      end
      if (w_capture) begin
        r_product <= w_capture_val;
      end
    end
  end

  // Outputs decode from registered state only
  assign bus.in_ready         = (r_state == S_IDLE);
  assign bus.mul_start        = (r_state == S_LAUNCH);
  assign bus.out_valid        = (r_state == S_OUTPUT);
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.out_product      = r_product;
  assign bus.mul_multiplicand = r_multiplicand;
  assign bus.mul_multiplier   = r_multiplier;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Directed bench for multiplier_sequencer with a behavioural multiplier core and a product scoreboard.
module tb_multiplier_sequencer;

  localparam int W   = 8;
  localparam int LAT = 3;
  localparam int MAXWAIT = 40;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2*W-1:0] sb[$];

  multiplier_sequencer_if #(.WIDTH(W)) bus ();

  multiplier_sequencer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural core: start -> LAT cycles -> ready with product, ready drops once start is released
  logic         core_ready;
  logic         core_busy;
  int           core_cnt;
  logic [2*W-1:0] core_prod;
  logic         stale_ready = 1'b0;

  assign bus.mul_ready   = core_ready | stale_ready;
  assign bus.mul_product = core_prod;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b0;
      core_busy  <= 1'b0;
      core_cnt   <= 0;
      core_prod  <= '0;
    end else if (!core_busy && !core_ready && bus.mul_start) begin
      core_busy <= 1'b1;
      core_cnt  <= LAT;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_ready <= 1'b1;
        core_busy  <= 1'b0;
        core_prod  <= {{W{1'b0}}, bus.mul_multiplicand} * {{W{1'b0}}, bus.mul_multiplier};
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else if (core_ready && !bus.mul_start) begin
      core_ready <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier   = b;
    sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    tick();
    bus.in_valid        = 1'b0;
    bus.in_multiplicand = W'($urandom);
    bus.in_multiplier   = W'($urandom);
    chk("accept_in_ready", 32'(bus.in_ready), 0);
    chk("accept_busy", 32'(bus.busy), 1);
    chk("accept_op_a", 32'(bus.mul_multiplicand), 32'(a));
    chk("accept_op_b", 32'(bus.mul_multiplier), 32'(b));
  endtask

  task automatic wait_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic unstable = 1'b0;
    logic [2*W-1:0] exp;
    while (!bus.out_valid && n < MAXWAIT) begin
      if (bus.mul_multiplicand !== a || bus.mul_multiplier !== b || bus.in_ready !== 1'b0)
        unstable = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < MAXWAIT), 1);
    chk({tag, "_operands_stable"}, 32'(unstable), 0);
    if (bus.out_valid && sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_product"}, 32'(bus.out_product), 32'(exp));
    end
  endtask

  task automatic transfer(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_idle_out_valid"}, 32'(bus.out_valid), 0);
  endtask

  task automatic wait_start_low(input string tag);
    int n = 0;
    while (bus.mul_start && n < MAXWAIT) begin
      tick();
      n++;
    end
    chk({tag, "_start_timeout"}, 32'(n < MAXWAIT), 1);
  endtask

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_multiplicand = '0;
    bus.in_multiplier   = '0;
    bus.out_ready       = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.in_valid        = 1'($urandom);
      bus.in_multiplicand = W'($urandom);
      bus.in_multiplier   = W'($urandom);
      bus.out_ready       = 1'($urandom);
      tick();
    end
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mul_start", 32'(bus.mul_start), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_product", 32'(bus.out_product), 0);
    chk("rst_op_a", 32'(bus.mul_multiplicand), 0);
    chk("rst_op_b", 32'(bus.mul_multiplier), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    chk("rel_busy", 32'(bus.busy), 0);

    // Basic 13 x 11
    accept(8'd13, 8'd11);
    chk("basic_start", 32'(bus.mul_start), 1);
    wait_start_low("basic");
    chk("basic_drain_product", 32'(bus.out_product), 143);
    chk("basic_drain_out_valid", 32'(bus.out_valid), 0);
    wait_out("basic", 8'd13, 8'd11);
    transfer("basic");

    // Stale core ready in IDLE and held ready in DRAIN
    stale_ready = 1'b1;
    tick(); tick(); tick();
    chk("stale_idle_busy", 32'(bus.busy), 0);
    chk("stale_idle_out_valid", 32'(bus.out_valid), 0);
    accept(8'd3, 8'd4);
    stale_ready = 1'b0;
    chk("stale_launch_start", 32'(bus.mul_start), 1);
    tick();
    chk("stale_still_launch", 32'(bus.mul_start), 1);
    wait_start_low("stale");
    stale_ready = 1'b1;
    tick(); tick(); tick();
    chk("stale_drain_out_valid", 32'(bus.out_valid), 0);
    chk("stale_drain_busy", 32'(bus.busy), 1);
    stale_ready = 1'b0;
    wait_out("stale", 8'd3, 8'd4);
    transfer("stale");

    // Back-pressure 255 x 255, then OUTPUT with in_valid and out_ready both high
    accept(8'd255, 8'd255);
    wait_out("bp", 8'd255, 8'd255);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_product_held", 32'(bus.out_product), 65025);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = 8'd2;
    bus.in_multiplier   = 8'd5;
    bus.out_ready       = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_xfer_in_ready", 32'(bus.in_ready), 1);
    chk("bp_xfer_out_valid", 32'(bus.out_valid), 0);
    chk("bp_xfer_no_start", 32'(bus.mul_start), 0);
    accept(8'd2, 8'd5);
    chk("bp_next_start", 32'(bus.mul_start), 1);
    wait_out("bp_next", 8'd2, 8'd5);
    transfer("bp_next");

    // Reset asserted during LAUNCH discards the operation
    accept(8'd6, 8'd6);
    chk("mr_in_launch", 32'(bus.mul_start), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 0);
    chk("mr_mul_start", 32'(bus.mul_start), 0);
    chk("mr_in_ready", 32'(bus.in_ready), 1);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_op_a", 32'(bus.mul_multiplicand), 0);
    sb.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    accept(8'd7, 8'd9);
    wait_out("mr_next", 8'd7, 8'd9);
    transfer("mr_next");

    // Zero operand
    accept(8'd0, 8'd200);
`ifdef MULTIPLIER_SEQUENCER_ZERO_BYPASS_EN
    chk("zero_bypass_out_valid", 32'(bus.out_valid), 1);
    chk("zero_bypass_no_start", 32'(bus.mul_start), 0);
`else
    chk("zero_start", 32'(bus.mul_start), 1);
`endif
    wait_out("zero", 8'd0, 8'd200);
    transfer("zero");
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
